// File: rtl/kitchen_order_server.sv
// Kitchen-side order server: queues {id, cook_time} requests and cooks them one at a time,
// signalling start_cooking / food_ready and waiting for serve_done before the next order.
module kitchen_order_server #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned TIME_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     place_order,
  input  logic [ID_W-1:0]          order_id,
  input  logic [TIME_W-1:0]        cook_time,
  output logic                     order_ready,
  output logic                     start_cooking,
  output logic                     food_ready,
  output logic [ID_W-1:0]          serve_id,
  input  logic                     serve_done,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [1:0]               state_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StCook  = 2'b10,
    StReady = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [TIME_W-1:0] timer_q, timer_d;
  logic [ID_W-1:0]   serve_id_q, serve_id_d;

  logic [ID_W-1:0]   id_mem   [DEPTH];
  logic [TIME_W-1:0] time_mem [DEPTH];

  logic push, pop;
  logic [TIME_W-1:0] head_time;

  // Full check uses the current count, so a pop on the same edge cannot free a slot.
  assign push      = place_order && (count_q < CntW'(DEPTH));
  assign pop       = (state_q == StIdle) && (count_q != '0);
  assign head_time = time_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr_q]   <= order_id;
      time_mem[wr_ptr_q] <= cook_time;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    serve_id_d = serve_id_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d    = StStart;
          serve_id_d = id_mem[rd_ptr_q];
          timer_d    = (head_time == '0) ? TIME_W'(1) : head_time;
        end
      end
      StStart: state_d = StCook;
      StCook: begin
        if (timer_q == TIME_W'(1)) begin
          state_d = StReady;
        end else begin
          timer_d = timer_q - TIME_W'(1);
        end
      end
      StReady: begin
        if (serve_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      serve_id_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      serve_id_q <= serve_id_d;
    end
  end

  assign order_ready   = (count_q < CntW'(DEPTH));
  assign start_cooking = (state_q == StStart);
  assign food_ready    = (state_q == StReady);
  assign serve_id      = serve_id_q;
  assign queue_count   = count_q;
  assign state_out     = state_q;

endmodule
